// File: rtl/xip_fetch_arbiter.sv
// xip_fetch_arbiter: shares one QPI XIP flash read port between an instruction
// fetch requester (m0, high priority) and a data load requester (m1, low
// priority with starvation protection). One command is latched and issued at a
// time; returned beats are registered and steered to the owning requester.
module xip_fetch_arbiter #(
   parameter int unsigned ADDR_W     = 24,
   parameter int unsigned BEAT_W     = 4,
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [2:0]        m0_size,
   input  logic [BEAT_W-1:0] m0_beats,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic              m0_rlast,
   input  logic              m1_req,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [2:0]        m1_size,
   input  logic [BEAT_W-1:0] m1_beats,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic              m1_rlast,
   output logic [63:0]       rdata,
   input  logic              x_ready,
   output logic              x_req,
   output logic [ADDR_W-1:0] x_addr,
   output logic [2:0]        x_size,
   output logic [BEAT_W-1:0] x_beats,
   input  logic              x_ack,
   input  logic              x_rvalid,
   input  logic [63:0]       x_rdata,
   output logic              err
);

   localparam int unsigned SW = $clog2(STARVE_LIM + 1);
   localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;

   logic [1:0]        state_q,    state_d;
   logic              owner_q,    owner_d;
   logic [ADDR_W-1:0] addr_q,     addr_d;
   logic [2:0]        size_q,     size_d;
   logic [BEAT_W-1:0] beats_q,    beats_d;
   logic [SW-1:0]     starve_q,   starve_d;
   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [63:0]       rdata_q,    rdata_d;
   logic              gnt0_q,     gnt0_d;
   logic              gnt1_q,     gnt1_d;
   logic              rv0_q,      rv0_d;
   logic              rv1_q,      rv1_d;
   logic              rl0_q,      rl0_d;
   logic              rl1_q,      rl1_d;
   logic              err_q,      err_d;
   logic              pick1;

   // Next-state: arbitration in IDLE, command handshake in ISSUE, beat steering in DATA.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      addr_d     = addr_q;
      size_d     = size_q;
      beats_d    = beats_q;
      starve_d   = starve_q;
      beat_cnt_d = beat_cnt_q;
      rdata_d    = rdata_q;
      gnt0_d     = 1'b0;
      gnt1_d     = 1'b0;
      rv0_d      = 1'b0;
      rv1_d      = 1'b0;
      rl0_d      = 1'b0;
      rl1_d      = 1'b0;
      pick1      = 1'b0;
      // A beat outside DATA has no owner: it is flagged and dropped.
      err_d      = err_q | (x_rvalid & (state_q != S_DATA));
      case (state_q)
         S_IDLE: begin
            if (!m1_req) begin
               starve_d = '0;
            end
            if (x_ready && (m0_req || m1_req)) begin
               pick1   = !m0_req || (m1_req && (starve_q == LIM));
               owner_d = pick1;
               addr_d  = pick1 ? m1_addr : m0_addr;
               size_d  = pick1 ? m1_size : m0_size;
               // Sub-64-bit sizes are always a single beat.
               if ((pick1 ? m1_size : m0_size) == 3'd3) begin
                  beats_d = pick1 ? m1_beats : m0_beats;
               end else begin
                  beats_d = '0;
               end
               if (pick1) begin
                  gnt1_d   = 1'b1;
                  starve_d = '0;
               end else begin
                  gnt0_d = 1'b1;
                  if (m1_req && (starve_q != LIM)) begin
                     starve_d = starve_q + SW'(1);
                  end
               end
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (x_ack) begin
               beat_cnt_d = '0;
               state_d    = S_DATA;
            end
         end
         S_DATA: begin
            if (x_rvalid) begin
               rdata_d    = x_rdata;
               beat_cnt_d = beat_cnt_q + BEAT_W'(1);
               rv0_d      = !owner_q;
               rv1_d      = owner_q;
               if (beat_cnt_q == beats_q) begin
                  rl0_d   = !owner_q;
                  rl1_d   = owner_q;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset abandons any outstanding command.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q    <= S_IDLE;
         owner_q    <= 1'b0;
         addr_q     <= '0;
         size_q     <= '0;
         beats_q    <= '0;
         starve_q   <= '0;
         beat_cnt_q <= '0;
         rdata_q    <= '0;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
         rv0_q      <= 1'b0;
         rv1_q      <= 1'b0;
         rl0_q      <= 1'b0;
         rl1_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         size_q     <= size_d;
         beats_q    <= beats_d;
         starve_q   <= starve_d;
         beat_cnt_q <= beat_cnt_d;
         rdata_q    <= rdata_d;
         gnt0_q     <= gnt0_d;
         gnt1_q     <= gnt1_d;
         rv0_q      <= rv0_d;
         rv1_q      <= rv1_d;
         rl0_q      <= rl0_d;
         rl1_q      <= rl1_d;
         err_q      <= err_d;
      end
   end

   assign m0_gnt    = gnt0_q;
   assign m1_gnt    = gnt1_q;
   assign m0_rvalid = rv0_q;
   assign m1_rvalid = rv1_q;
   assign m0_rlast  = rl0_q;
   assign m1_rlast  = rl1_q;
   assign rdata     = rdata_q;
   assign x_req     = (state_q == S_ISSUE);
   assign x_addr    = addr_q;
   assign x_size    = size_q;
   assign x_beats   = beats_q;
   assign err       = err_q;

endmodule

// File: tb/tb_xip_fetch_arbiter.sv
// Self-checking bench for xip_fetch_arbiter: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a transaction-level
// reference model of the arbiter.
module tb_xip_fetch_arbiter;

   localparam int unsigned ADDR_W     = 24;
   localparam int unsigned BEAT_W     = 4;
   localparam int unsigned STARVE_LIM = 4;

   logic              HCLK = 1'b0;
   logic              HRESET = 1'b0;
   logic              m0_req = 1'b0, m1_req = 1'b0;
   logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
   logic [2:0]        m0_size = '0, m1_size = '0;
   logic [BEAT_W-1:0] m0_beats = '0, m1_beats = '0;
   logic              m0_gnt, m0_rvalid, m0_rlast;
   logic              m1_gnt, m1_rvalid, m1_rlast;
   logic [63:0]       rdata;
   logic              x_ready = 1'b0, x_ack = 1'b0, x_rvalid = 1'b0;
   logic [63:0]       x_rdata = '0;
   logic              x_req, err;
   logic [ADDR_W-1:0] x_addr;
   logic [2:0]        x_size;
   logic [BEAT_W-1:0] x_beats;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   xip_fetch_arbiter #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .STARVE_LIM(STARVE_LIM)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_size(m0_size), .m0_beats(m0_beats),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rlast(m0_rlast),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_size(m1_size), .m1_beats(m1_beats),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rlast(m1_rlast),
      .rdata(rdata), .x_ready(x_ready), .x_req(x_req), .x_addr(x_addr),
      .x_size(x_size), .x_beats(x_beats), .x_ack(x_ack), .x_rvalid(x_rvalid),
      .x_rdata(x_rdata), .err(err)
   );

   always #5 HCLK = ~HCLK;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   // ---------------- reference model (transaction level) ----------------
   bit                mb_busy, mb_acked, mb_owner, mb_err;
   logic [ADDR_W-1:0] mb_addr;
   logic [2:0]        mb_size;
   logic [BEAT_W-1:0] mb_beats;
   int                mb_left, mb_starve;
   bit                e_gnt0, e_gnt1, e_rv0, e_rv1, e_rl0, e_rl1;
   logic [63:0]       e_rdata;

   task automatic model_reset();
      mb_busy = 0; mb_acked = 0; mb_owner = 0; mb_err = 0;
      mb_addr = '0; mb_size = '0; mb_beats = '0; mb_left = 0; mb_starve = 0;
      e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_rl0 = 0; e_rl1 = 0;
      e_rdata = '0;
   endtask

   task automatic model_step();
      bit pick1;
      e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_rl0 = 0; e_rl1 = 0;
      if (!mb_busy) begin
         if (x_rvalid) mb_err = 1;
         if (!m1_req) mb_starve = 0;
         if (x_ready && (m0_req || m1_req)) begin
            pick1 = !m0_req || (m1_req && mb_starve == int'(STARVE_LIM));
            if (pick1) begin
               mb_owner = 1; mb_addr = m1_addr; mb_size = m1_size;
               mb_beats = (m1_size == 3'd3) ? m1_beats : '0;
               e_gnt1 = 1; mb_starve = 0;
            end else begin
               mb_owner = 0; mb_addr = m0_addr; mb_size = m0_size;
               mb_beats = (m0_size == 3'd3) ? m0_beats : '0;
               e_gnt0 = 1;
               if (m1_req) mb_starve = (mb_starve + 1 > int'(STARVE_LIM)) ? int'(STARVE_LIM) : mb_starve + 1;
            end
            mb_busy = 1; mb_acked = 0;
         end
      end else if (!mb_acked) begin
         if (x_rvalid) mb_err = 1;
         if (x_ack) begin
            mb_acked = 1;
            mb_left  = int'(mb_beats) + 1;
         end
      end else if (x_rvalid) begin
         e_rdata = x_rdata;
         mb_left--;
         if (mb_owner) begin e_rv1 = 1; e_rl1 = (mb_left == 0); end
         else          begin e_rv0 = 1; e_rl0 = (mb_left == 0); end
         if (mb_left == 0) mb_busy = 0;
      end
   endtask

   task automatic compare();
      bit exp_xreq;
      exp_xreq = mb_busy && !mb_acked;
      check_eq("gnt", 128'({m1_gnt, m0_gnt}), 128'({e_gnt1, e_gnt0}));
      check_eq("rvalid_rlast", 128'({m1_rvalid, m1_rlast, m0_rvalid, m0_rlast}),
               128'({e_rv1, e_rl1, e_rv0, e_rl0}));
      if (e_rv0 || e_rv1) check_eq("rdata", 128'(rdata), 128'(e_rdata));
      check_eq("x_req", 128'(x_req), 128'(exp_xreq));
      if (exp_xreq) check_eq("x_cmd", 128'({x_addr, x_size, x_beats}), 128'({mb_addr, mb_size, mb_beats}));
      check_eq("err", 128'(err), 128'(mb_err));
   endtask

   task automatic cycle();
      @(posedge HCLK);
      model_step();
      @(negedge HCLK);
      compare();
   endtask

   function automatic logic [127:0] all_outs();
      return 128'({m0_gnt, m0_rvalid, m0_rlast, m1_gnt, m1_rvalid, m1_rlast,
                   rdata, x_req, x_addr, x_size, x_beats, err});
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic wait_gnt(input bit who, input string tag, output int n);
      bit seen;
      seen = 0; n = 0;
      while (!seen && n < 40) begin
         cycle(); n++;
         seen = who ? m1_gnt : m0_gnt;
      end
      check_eq(tag, 128'(seen), 128'(1));
   endtask

   task automatic wait_any(output bit who);
      bit seen;
      int n;
      seen = 0; n = 0; who = 0;
      while (!seen && n < 40) begin
         cycle(); n++;
         seen = m0_gnt | m1_gnt;
         who  = m1_gnt;
      end
      check_eq("wait_any_gnt", 128'(seen), 128'(1));
   endtask

   // Flash side: ack after ack_dly cycles, then nbeats beats with optional gaps.
   task automatic serve(input int ack_dly, input int nbeats, input logic [63:0] d0);
      x_ack = 0;
      repeat (ack_dly) cycle();
      x_ack = 1; cycle(); x_ack = 0;
      for (int b = 0; b < nbeats; b++) begin
         x_rvalid = 1;
         x_rdata  = (b == 0) ? d0 : {$urandom, $urandom};
         cycle();
         x_rvalid = 0;
         if (b < nbeats - 1 && $urandom_range(0, 2) == 0) cycle();
      end
   endtask

   task automatic rand_m0();
      m0_addr = ADDR_W'($urandom); m0_size = 3'($urandom_range(0, 3)); m0_beats = BEAT_W'($urandom_range(0, 15));
   endtask

   task automatic rand_m1();
      m1_addr = ADDR_W'($urandom); m1_size = 3'($urandom_range(0, 3)); m1_beats = BEAT_W'($urandom_range(0, 15));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int  n;
      bit  who;
      logic [9:0] order, exp_order;
      int  sc;
      int  m1_early;

      model_reset();
      #2 HRESET = 1;
      repeat (2) @(negedge HCLK);
      check_eq("reset_outputs", all_outs(), 128'(0));

      // Held off until the controller is ready.
      m0_req = 1; m0_addr = 24'h123456; m0_size = 3'd3; m0_beats = 4'd2;
      HRESET = 0;
      repeat (20) cycle();
      x_ready = 1;
      wait_gnt(0, "ready_gnt", n);
      check_eq("ready_gnt_latency", 128'(n), 128'(1));
      check_eq("ready_x_addr", 128'(x_addr), 128'(24'h123456));
      m0_req = 0;
      serve(0, 3, {$urandom, $urandom});

      // Single read: sub-64-bit size forces one beat.
      m0_req = 1; m0_addr = 24'h000100; m0_size = 3'd2; m0_beats = 4'd7;
      wait_gnt(0, "single_gnt", n);
      m0_req = 0;
      check_eq("single_x_beats", 128'(x_beats), 128'(0));
      serve(3, 1, 64'hDEADBEEF_01234567);
      check_eq("single_beat", 128'({m0_rvalid, m0_rlast, rdata}), 128'({2'b11, 64'hDEADBEEF_01234567}));
      cycle();

      // Burst of four for m0 while m1 waits; m1 granted only afterwards.
      m0_req = 1; m0_addr = 24'h004000; m0_size = 3'd3; m0_beats = 4'd3;
      wait_gnt(0, "burst_gnt", n);
      m0_req = 0;
      m1_req = 1; m1_addr = 24'h00A000; m1_size = 3'd1; m1_beats = 4'd5;
      m1_early = 0;
      x_ack = 1; cycle(); x_ack = 0;
      for (int b = 0; b < 4; b++) begin
         x_rvalid = 1; x_rdata = {$urandom, $urandom};
         cycle();
         x_rvalid = 0;
         m1_early += int'(m1_gnt);
         check_eq("burst_rlast", 128'(m0_rlast), 128'(b == 3));
      end
      check_eq("burst_no_m1_gnt", 128'(m1_early), 128'(0));
      wait_gnt(1, "burst_m1_gnt", n);
      check_eq("burst_m1_latency", 128'(n), 128'(1));
      m1_req = 0;
      serve(1, 1, {$urandom, $urandom});
      cycle();

      // Both requesters held: starvation protection shapes the grant order.
      m0_req = 1; m0_size = 3'd0; m1_req = 1; m1_size = 3'd2;
      order = '0; exp_order = '0; sc = 0;
      for (int g = 0; g < 10; g++) begin
         if (sc == int'(STARVE_LIM)) begin exp_order[g] = 1'b1; sc = 0; end
         else sc++;
         m0_addr = ADDR_W'($urandom); m1_addr = ADDR_W'($urandom);
         wait_any(who);
         order[g] = who;
         serve($urandom_range(0, 2), 1, {$urandom, $urandom});
      end
      check_eq("grant_order", 128'(order), 128'(exp_order));
      m0_req = 0; m1_req = 0;
      cycle();

      // Stray beat while idle: sticky error, nothing routed.
      x_rvalid = 1; x_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
      cycle();
      x_rvalid = 0;
      repeat (4) cycle();
      check_eq("err_sticky", 128'({err, m0_rvalid, m1_rvalid}), 128'(3'b100));

      // Reset in the middle of an 8-beat burst.
      m0_req = 1; m0_addr = 24'h0F0000; m0_size = 3'd3; m0_beats = 4'd7;
      wait_gnt(0, "midrst_gnt", n);
      m0_req = 0;
      x_ack = 1; cycle(); x_ack = 0;
      for (int b = 0; b < 2; b++) begin
         x_rvalid = 1; x_rdata = {$urandom, $urandom};
         cycle();
      end
      x_rvalid = 0;
      #2 HRESET = 1;
      #1 check_eq("midrst_outputs", all_outs(), 128'(0));
      model_reset();
      m1_req = 1; m1_addr = 24'h0ABCDE; m1_size = 3'd3; m1_beats = 4'd1;
      @(negedge HCLK);
      HRESET = 0;
      wait_gnt(1, "post_rst_m1_gnt", n);
      m1_req = 0;
      serve(2, 2, {$urandom, $urandom});
      cycle();

      // Randomized traffic against the model.
      for (int c = 0; c < 2500; c++) begin
         x_ready = ($urandom_range(0, 5) != 0);
         if (!m0_req && $urandom_range(0, 2) == 0) begin m0_req = 1; rand_m0(); end
         if (!m1_req && $urandom_range(0, 2) == 0) begin m1_req = 1; rand_m1(); end
         x_ack    = mb_busy && !mb_acked && ($urandom_range(0, 1) == 1);
         x_rvalid = mb_busy && mb_acked && ($urandom_range(0, 1) == 1);
         x_rdata  = {$urandom, $urandom};
         cycle();
         if (m0_gnt) begin
            if ($urandom_range(0, 1) == 1) rand_m0(); else m0_req = 0;
         end
         if (m1_gnt) begin
            if ($urandom_range(0, 1) == 1) rand_m1(); else m1_req = 0;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
